// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_sequencer slice.
//   - opcode encoding (instruction bits [7:5])
//   - FSM state encoding for cpu_sequencer
//   - instruction word layout
//   - WAIT timeout limit, used when SEQ_TIMEOUT_EN is defined
package cpu_pkg;

  localparam int DATA_W = 8;

  // Cycles allowed in WAIT before the sequencer gives up on alu_done.
  localparam int TIMEOUT_LIMIT = 16;
  localparam int TIMEOUT_CNT_W = $clog2(TIMEOUT_LIMIT);
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_LIMIT - 1);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef struct packed {
    opcode_t    op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       last;
  } instr_t;

  // mul and div are handed to the external ALU and completed by alu_done.
  function automatic logic is_multicycle(opcode_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 4 x DATA_W register file.
//   clk, rst_n          : clock, synchronous active-low reset (clears all registers)
//   we, waddr, wdata    : single synchronous write port
//   raddr_a / rdata_a   : combinational read port (destination operand)
//   raddr_b / rdata_b   : combinational read port (source operand)
//   dbg_addr/dbg_rdata  : combinational debug read port
module seq_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign dbg_rdata = regs[dbg_addr];

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle micro-sequencer driving an external ALU.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, abort          : begin a program at pc=0 / return to IDLE at once
//   imem_addr, imem_rdata : instruction memory (1-cycle synchronous read)
//   alu_sel/a/b, alu_result, alu_start, alu_done : external ALU handshake
//   cfg_we/addr/wdata     : register preload, honored only while idle
//   dbg_addr, dbg_rdata   : combinational register read-back
//   busy, done, flag, err, pc : status
// Build option: define SEQ_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_LIMIT cycles and raise the sticky err flag; otherwise WAIT
// waits indefinitely and err stays 0.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [7:0]        imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              done,
  output logic              flag,
  output logic              err,
  output logic [7:0]        pc
);

  state_t            state;
  instr_t            ir;
  instr_t            fetched;
  logic [DATA_W-1:0] result;
  logic [1:0]        rd_sel, rs_sel;
  logic [DATA_W-1:0] rd_data, rs_data;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] wait_cnt;
`endif

  assign fetched   = instr_t'(imem_rdata);
  assign imem_addr = pc;
  assign busy      = (state != S_IDLE);

  // During DECODE the read ports follow the word arriving from memory, so
  // the operands can be registered straight onto alu_a/alu_b for EXEC.
  assign rd_sel = (state == S_DECODE) ? fetched.rd : ir.rd;
  assign rs_sel = (state == S_DECODE) ? fetched.rs : ir.rs;

  // One write port shared by the idle-time preload and the writeback.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ir.rd;
    rf_wdata = result;
    if (state == S_IDLE && cfg_we) begin
      rf_we    = 1'b1;
      rf_waddr = cfg_addr;
      rf_wdata = cfg_wdata;
    end else if (state == S_WB && !abort && ir.op != OP_CMP) begin
      rf_we = 1'b1;
    end
  end

  seq_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr_a   (rd_sel),
    .raddr_b   (rs_sel),
    .dbg_addr  (dbg_addr),
    .rdata_a   (rd_data),
    .rdata_b   (rs_data),
    .dbg_rdata (dbg_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      result    <= '0;
      done      <= 1'b0;
      flag      <= 1'b0;
      err       <= 1'b0;
      alu_start <= 1'b0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      alu_start <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        alu_sel <= '0;
        alu_a   <= '0;
        alu_b   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pc    <= '0;
              err   <= 1'b0;
              state <= S_FETCH;
            end
          end
          // imem_addr=pc is presented here; data is valid in DECODE.
          S_FETCH: state <= S_DECODE;
          // Operands and alu_start are registered so they are valid in EXEC.
          S_DECODE: begin
            ir        <= fetched;
            alu_sel   <= fetched.op;
            alu_a     <= rd_data;
            alu_b     <= rs_data;
            alu_start <= is_multicycle(fetched.op);
            state     <= S_EXEC;
          end
          S_EXEC: begin
            if (is_multicycle(ir.op)) begin
              state <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              result  <= alu_result;
              alu_sel <= '0;
              alu_a   <= '0;
              alu_b   <= '0;
              state   <= S_WB;
            end
          end
          // Operands stay put until the ALU reports completion.
          S_WAIT: begin
            if (alu_done) begin
              result  <= alu_result;
              alu_sel <= '0;
              alu_a   <= '0;
              alu_b   <= '0;
              state   <= S_WB;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wait_cnt == TIMEOUT_LAST) begin
              err     <= 1'b1;
              alu_sel <= '0;
              alu_a   <= '0;
              alu_b   <= '0;
              state   <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
          // Register write happens through the shared write port this cycle.
          S_WB: begin
            pc <= pc + 8'd1;
            if (ir.op == OP_CMP) flag <= result[0];
            if (ir.last) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_FETCH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed scoreboard bench for cpu_sequencer.
// The stimulus process pushes the expected end-of-program state when it
// issues start; the monitor pops and compares on every done pulse.
// Define SEQ_TIMEOUT_EN for both bench and RTL to exercise the WAIT timeout.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic [2:0] alu_sel;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_result;
  logic       alu_start;
  logic       alu_done = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'h00;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_rdata;
  logic       busy, done, flag, err;
  logic [7:0] pc;

  cpu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .dbg_addr   (dbg_addr),
    .dbg_rdata  (dbg_rdata),
    .busy       (busy),
    .done       (done),
    .flag       (flag),
    .err        (err),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with one-cycle synchronous read.
  logic [7:0] imem [256];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  // ALU model: result combinational; alu_done alu_delay cycles after alu_start.
  logic [15:0] prod;
  always_comb begin
    alu_result = 8'h00;
    prod = 16'(alu_a) * 16'(alu_b);
    case (alu_sel)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = prod[7:0];
      3'd6: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
      default: alu_result = {7'd0, alu_a < alu_b};
    endcase
  end

  int alu_delay = 1;
  bit alu_never = 1'b0;
  int dcnt = 0;
  int start_pulses = 0;
  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (alu_start) start_pulses <= start_pulses + 1;
    if (alu_start && !alu_never) begin
      if (alu_delay <= 1) alu_done <= 1'b1;
      else dcnt <= alu_delay - 1;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) alu_done <= 1'b1;
    end
  end

  // Debug port shared between stimulus and monitor.
  logic       mon_sel = 1'b0;
  logic [1:0] mon_addr = 2'd0;
  logic [1:0] stim_addr = 2'd0;
  assign dbg_addr = mon_sel ? mon_addr : stim_addr;

  int n_checks = 0;
  int n_pass = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  typedef struct {
    int              lat;
    int              start_cyc;
    logic            flag;
    logic            err;
    logic [3:0][7:0] r;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] er [4];
  logic       eflag = 1'b0;

  // Monitor: every done pulse consumes one expected program result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          chk("done_without_program", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("flag", 32'(flag), 32'(e.flag));
          chk("err", 32'(err), 32'(e.err));
          chk("busy_at_done", 32'(busy), 32'd0);
          mon_sel = 1'b1;
          for (int i = 0; i < 4; i++) begin
            mon_addr = 2'(i);
            #1;
            chk($sformatf("r%0d", i), 32'(dbg_rdata), 32'(e.r[i]));
          end
          mon_sel = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
    stim_addr = a;
    #1;
    v = dbg_rdata;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic begin_prog(input int lat);
    exp_t e;
    e.lat = lat; e.start_cyc = cyc; e.flag = eflag; e.err = 1'b0;
    for (int i = 0; i < 4; i++) e.r[i] = er[i];
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_count;
    for (int i = 0; i < budget && done_count == d0; i++) tick();
    chk({name, "_done_seen"}, 32'(done_count - d0), 32'd1);
    if (done_count == d0) exp_q.delete();
    tick(3);
    chk({name, "_done_once"}, 32'(done_count - d0), 32'd1);
  endtask

  task automatic wait_alu_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (alu_start) seen = 1'b1;
      else tick();
    end
    chk("alu_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    logic [7:0] v;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_flag"}, 32'(flag), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), v);
      chk($sformatf("%s_r%0d", tag, i), 32'(v), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] v;
    bit seen;
    bit wrapped;
    int d0, p0, e_cyc;
    logic [7:0] prev_pc;

    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int i = 0; i < 4; i++) er[i] = 8'h00;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // abort wins over start
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_prio_busy", 32'(busy), 32'd0);
    tick();

    // add R0=R0+R1, 5 + 3
    cfg_write(2'd0, 8'd5);
    cfg_write(2'd1, 8'd3);
    imem[0] = 8'h03;
    er[0] = 8'd8; er[1] = 8'd3;
    begin_prog(5);
    wait_done("add", 30);
    chk("add_pc", 32'(pc), 32'd1);

    // mul R2=R2*R2 (0x0C*0x0C=0x90), then cmp R2 < R1 (0x90 < 0xA0)
    cfg_write(2'd2, 8'h0C);
    cfg_write(2'd1, 8'hA0);
    imem[0] = 8'hB4;
    imem[1] = 8'hF3;
    alu_delay = 3;
    er[1] = 8'hA0; er[2] = 8'h90; eflag = 1'b1;
    p0 = start_pulses;
    begin_prog(12);
    wait_alu_start(seen);
    chk("mul_sel", 32'(alu_sel), 32'd5);
    chk("mul_a", 32'(alu_a), 32'h0C);
    chk("mul_b", 32'(alu_b), 32'h0C);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wait%0d_alu_start", k), 32'(alu_start), 32'd0);
      chk($sformatf("wait%0d_sel", k), 32'(alu_sel), 32'd5);
      chk($sformatf("wait%0d_a", k), 32'(alu_a), 32'h0C);
      chk($sformatf("wait%0d_b", k), 32'(alu_b), 32'h0C);
    end
    tick();
    chk("wb_alu_sel_zero", 32'(alu_sel), 32'd0);
    chk("wb_alu_a_zero", 32'(alu_a), 32'd0);
    wait_done("mulcmp", 30);
    chk("mulcmp_start_pulses", 32'(start_pulses - p0), 32'd1);
    chk("mulcmp_pc", 32'(pc), 32'd2);

    // sub/and/or/xor/cmp chain with wrap-around subtraction
    imem[0] = 8'h38; imem[1] = 8'h4C; imem[2] = 8'h62; imem[3] = 8'h96; imem[4] = 8'hF9;
    er[0] = 8'h88; er[1] = 8'h80; er[2] = 8'h68; er[3] = 8'hF8; eflag = 1'b0;
    begin_prog(21);
    wait_done("chain", 40);

    // div R3=R3/R2 (0xF8/0x68=2), alu_done one cycle after alu_start
    imem[0] = 8'hDD;
    alu_delay = 1;
    er[3] = 8'h02;
    begin_prog(6);
    wait_done("div", 30);

    // abort during EXEC of add R1=R1+R0
    imem[0] = 8'h09;
    d0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    chk("abort_busy_in_exec", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu_sel", 32'(alu_sel), 32'd0);
    read_reg(2'd1, v);
    chk("abort_r1", 32'(v), 32'h80);
    tick(6);
    chk("abort_no_done", 32'(done_count - d0), 32'd0);
    chk("abort_flag", 32'(flag), 32'd0);

    // div that never completes: cfg while busy, then timeout or reset in WAIT
    imem[0] = 8'hDD;
    alu_never = 1'b1;
    d0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_alu_start(seen);
    e_cyc = cyc;
    tick();
    cfg_write(2'd0, 8'h55);
    read_reg(2'd0, v);
    chk("cfg_busy_r0", 32'(v), 32'h88);
    chk("cfg_busy_busy", 32'(busy), 32'd1);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("timeout_cycles", 32'(cyc - e_cyc), 32'd17);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_err", 32'(err), 32'd1);
    read_reg(2'd3, v);
    chk("timeout_r3", 32'(v), 32'h02);
    chk("timeout_no_done", 32'(done_count - d0), 32'd0);
    // new program clears err: add R1=R1+R0 = 0x80+0x88
    imem[0] = 8'h09;
    er[1] = 8'h08;
    begin_prog(5);
    chk("restart_err_clear", 32'(err), 32'd0);
    wait_done("restart", 30);
    imem[0] = 8'hDD;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_alu_start(seen);
    tick(2);
`else
    tick(20);
    chk("nowait_busy", 32'(busy), 32'd1);
    chk("nowait_err", 32'(err), 32'd0);
`endif
    // reset while in WAIT
    rst_n = 1'b0;
    tick();
    check_all_zero("wait_reset");
    tick();
    rst_n = 1'b1;
    alu_never = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) er[i] = 8'h00;
    eflag = 1'b0;

    // 256 non-last adds then the last add at address 0 again; cfg with start
    for (int i = 0; i < 256; i++) imem[i] = 8'h02;
    er[0] = 8'h01; er[1] = 8'h01;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h01;
    begin_prog(1029);
    tick(3);
    imem[0] = 8'h03;
    wrapped = 1'b0;
    d0 = done_count;
    for (int i = 0; i < 1100 && done_count == d0; i++) begin
      prev_pc = pc;
      tick();
      if (prev_pc == 8'hFF && pc == 8'h00) wrapped = 1'b1;
    end
    chk("wrap_seen", 32'(wrapped), 32'd1);
    chk("wrap_done", 32'(done_count - d0), 32'd1);
    if (done_count == d0) exp_q.delete();
    chk("wrap_pc", 32'(pc), 32'd1);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 synchronous active-low reset.
REQ-002 SHALL have these ports: start input 1, one-cycle pulse that begins a program at pc=0; abort input 1, synchronous stop.
REQ-003 SHALL have instruction-memory ports: imem_addr output 8, equals pc; imem_rdata input 8, synchronous-read data valid one cycle after imem_addr.
REQ-004 SHALL have ALU ports: alu_sel output 3; alu_a output 8; alu_b output 8; alu_result input 8, combinational from operands; alu_start output 1; alu_done input 1.
REQ-005 SHALL have register-load ports: cfg_we input 1; cfg_addr input 2; cfg_wdata input 8.
REQ-006 SHALL have a debug read port: dbg_addr input 2; dbg_rdata output 8, combinational read of R[dbg_addr].
REQ-007 SHALL have status outputs: busy output 1; done output 1, one-cycle pulse; flag output 1, last compare result; err output 1, sticky timeout error; pc output 8.

Function
REQ-008 SHALL decode the instruction word as: opcode=[7:5] (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 mul, 110 div, 111 cmp), rd=[4:3], rs=[2:1], last=[0].
REQ-009 SHALL use FSM states IDLE, FETCH, DECODE, EXEC, WAIT, WB, with busy=1 in every state except IDLE.
REQ-010 SHALL, in IDLE, on start=1 with abort=0, set pc=0, clear err and go to FETCH.
REQ-011 SHALL go from FETCH to DECODE unconditionally.
REQ-012 SHALL, in DECODE, latch imem_rdata into the instruction register and go to EXEC.
REQ-013 SHALL, in EXEC, drive alu_sel=opcode, alu_a=R[rd] and alu_b=R[rs].
REQ-014 SHALL, in EXEC for opcodes 000-100 and 111, capture alu_result and go to WB.
REQ-015 SHALL, in EXEC for opcodes 101 and 110, pulse alu_start for one cycle and go to WAIT.
REQ-016 SHALL, in WAIT, hold alu_sel, alu_a and alu_b stable, keep alu_start=0, and on alu_done=1 capture alu_result and go to WB.
REQ-017 SHALL drive alu_sel, alu_a and alu_b to 0 in all states other than EXEC and WAIT.
REQ-018 SHALL, in WB for opcode 111, set flag=result[0] and leave the register file unchanged.
REQ-019 SHALL, in WB for any other opcode, write R[rd]=result.
REQ-020 SHALL increment pc modulo 256 in WB, so that 255 wraps to 0.
REQ-021 SHALL, in WB, go to IDLE and pulse done on the next cycle if last=1, and otherwise go to FETCH.
REQ-022 SHALL take 4 cycles per single-cycle instruction, from FETCH to WB inclusive.
REQ-023 SHALL, on abort=1 in any state, go to IDLE on the next edge with no register write, no flag update and no done pulse.
REQ-024 SHALL give abort priority over start.
REQ-025 SHALL honor cfg_we only in IDLE and ignore it while busy=1.
REQ-026 SHALL, when cfg_we=1 and start=1 occur in the same IDLE cycle, perform the write and start the program.
REQ-027 SHALL use all arithmetic modulo 2^8, with no carry or overflow state.

Reset
REQ-028 SHALL, when rst_n=0 at an edge, set state=IDLE, pc=0 and R0-R3=0.
REQ-029 SHALL drive busy, done, flag, err, alu_start, alu_sel, alu_a and alu_b to 0 while in reset.
REQ-030 SHALL abandon any instruction in progress when reset occurs, including an outstanding WAIT.

Configuration
REQ-031 SHALL, with SEQ_TIMEOUT_EN defined, count cycles spent in WAIT, and on reaching 16 cycles without alu_done set err=1 and go to IDLE with no writeback and no done pulse.
REQ-032 SHALL, without SEQ_TIMEOUT_EN, wait indefinitely for alu_done, with err tied to 0.

Structure
REQ-033 SHALL place the opcode constants, the FSM state encoding and the timeout limit (16) in the shared package cpu_pkg.
REQ-034 SHALL implement the 4x8 register file, with one synchronous write port and two combinational read ports plus the debug read, as the sub-module seq_regfile.

Verification
REQ-035 SHALL cover: load R0=5 and R1=3, program {000_00_01_1} (add), start -> R0=8, done exactly 5 cycles after start, busy=0.
REQ-036 SHALL cover: load R2=0x0C, program {101_10_10_0, 111_10_01_1} (mul then cmp), alu_done 3 cycles after alu_start -> alu_start is a single pulse, operands stable through WAIT, R2 takes the mul result, flag=result[0] of the cmp, done asserts once.
REQ-037 SHALL cover: abort asserted in EXEC of an add -> the next state is IDLE, the destination register is unchanged, and done stays 0.
REQ-038 SHALL cover: with SEQ_TIMEOUT_EN, a div with alu_done never asserted -> err=1 after 16 WAIT cycles, state IDLE, R[rd] unchanged; a new start clears err.
REQ-039 SHALL cover: 256 non-last instructions followed by a last instruction at address 0 -> pc wraps from 255 to 0 and done pulses after the wrapped instruction.
REQ-040 SHALL cover: cfg_we=1 while busy -> the register is unchanged; rst_n=0 during WAIT -> all outputs are 0 and R0-R3=0.
